// File: rtl/cdb_result_broadcaster.sv
// cdb_result_broadcaster: gathers completed results from NUM_SRC functional
// units into small per-source FIFOs, then round-robin arbitrates one
// registered tag/value broadcast per cycle onto the common data bus.
// Tag 0 on the bus means "no broadcast".
//
// Handshakes: a source transfers on an edge where srcValid_i and srcReady_o
// are both high. srcReady_o comes from registered state only. The bus side
// is held while cdbValid_o & cdbStall_i, and advances otherwise.
module cdb_result_broadcaster #(
    parameter int ROBsize    = 16,
    parameter int ROBsizeLog = $clog2(ROBsize + 1),
    parameter int NUM_SRC    = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            needToRestore_i,
    input  logic [NUM_SRC-1:0]              srcValid_i,
    input  logic [NUM_SRC*ROBsizeLog-1:0]   srcTag_i,
    input  logic [NUM_SRC*64-1:0]           srcVal_i,
    output logic [NUM_SRC-1:0]              srcReady_o,
    input  logic                            cdbStall_i,
    output logic [ROBsizeLog-1:0]           cdbTag_o,
    output logic [64:0]                     cdbVal_o,
    output logic                            cdbValid_o,
    output logic                            fifoOverflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [ROBsizeLog-1:0] tag_mem [NUM_SRC][FIFO_DEPTH];
    logic [63:0]           val_mem [NUM_SRC][FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr  [NUM_SRC];
    logic [AW-1:0]         rd_ptr  [NUM_SRC];
    logic [CW-1:0]         count   [NUM_SRC];

    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         win;
    logic [PW-1:0]         rr_next;
    logic                  found;
    logic                  load;
    logic [NUM_SRC-1:0]    src_ready;
    logic [NUM_SRC-1:0]    push;
    logic [NUM_SRC-1:0]    pop;
    logic                  overflow_hit;

    assign load       = ~cdbValid_o | ~cdbStall_i;
    assign srcReady_o = src_ready;

    // Round-robin scan starting at rr_ptr; first non-empty FIFO wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && count[(int'(rr_ptr) + i) % NUM_SRC] != '0) begin
                found = 1'b1;
                win   = PW'((int'(rr_ptr) + i) % NUM_SRC);
            end
        end
        rr_next = (int'(win) == NUM_SRC - 1) ? '0 : win + PW'(1);
    end

    // Per-source ready, push and pop strobes; a flush suppresses both.
    always_comb begin
        src_ready = '0;
        push      = '0;
        pop       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src_ready[k] = (count[k] != CW'(FIFO_DEPTH));
            push[k] = srcValid_i[k] & src_ready[k] & ~needToRestore_i
                    & (srcTag_i[k*ROBsizeLog +: ROBsizeLog] != '0);
            pop[k]  = load & found & (win == PW'(k)) & ~needToRestore_i;
        end
        overflow_hit = |(srcValid_i & ~src_ready);
    end

    // FIFO storage: written at the tail on a push; contents need no reset.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_SRC; k++) begin
            if (push[k]) begin
                tag_mem[k][wr_ptr[k]] <= srcTag_i[k*ROBsizeLog +: ROBsizeLog];
                val_mem[k][wr_ptr[k]] <= srcVal_i[k*64 +: 64];
            end
        end
    end

    // FIFO pointers and occupancy; flush empties every FIFO.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
        end else if (needToRestore_i) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (push[k]) wr_ptr[k] <= wr_ptr[k] + AW'(1);
                if (pop[k])  rd_ptr[k] <= rd_ptr[k] + AW'(1);
                if (push[k] && !pop[k])      count[k] <= count[k] + CW'(1);
                else if (pop[k] && !push[k]) count[k] <= count[k] - CW'(1);
            end
        end
    end

    // Broadcast register and round-robin pointer.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cdbValid_o <= 1'b0;
            cdbTag_o   <= '0;
            cdbVal_o   <= '0;
            rr_ptr     <= '0;
        end else if (needToRestore_i) begin
            cdbValid_o <= 1'b0;
            cdbTag_o   <= '0;
            cdbVal_o   <= '0;
            rr_ptr     <= '0;
        end else if (load) begin
            if (found) begin
                cdbValid_o <= 1'b1;
                cdbTag_o   <= tag_mem[win][rd_ptr[win]];
                cdbVal_o   <= {1'b1, val_mem[win][rd_ptr[win]]};
                rr_ptr     <= rr_next;
            end else begin
                cdbValid_o <= 1'b0;
                cdbTag_o   <= '0;
                cdbVal_o   <= '0;
            end
        end
    end

    // Sticky overflow: a source offered data while its FIFO was full.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)          fifoOverflow_o <= 1'b0;
        else if (overflow_hit) fifoOverflow_o <= 1'b1;
    end

endmodule
